cons_reader: RTL and testbench

//  Read-side initiator for the heap: dereferences a tagged cons word into car/cdr by

---
 rtl/lisp_defs.sv | 38 +++
 rtl/cons_reader.sv | 210 +++++++++++++++++++++
 tb/tb_cons_reader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lisp_defs.sv
// Shared heap word definitions for the Lisp evaluator datapath.
// Word layout: {1'b0, type[14:12], addr[11:0]}; address 0 is reserved for NIL.
package lisp_defs;

  localparam int WordWidth = 16;
  localparam int AddrWidth = 12;

  localparam logic [2:0]           TYPE_CONS = 3'd1;
  localparam logic [WordWidth-1:0] LISP_NIL  = 16'h0000;

  typedef enum logic [1:0] {
    OP_CAR  = 2'd0,
    OP_CDR  = 2'd1,
    OP_PAIR = 2'd2,
    OP_NTH  = 2'd3
  } reader_op_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TYPE    = 2'd1,
    ERR_NIL     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } reader_err_t;

  function automatic logic [2:0] word_type(input logic [WordWidth-1:0] w);
    return w[14:12];
  endfunction

  function automatic logic [AddrWidth-1:0] word_addr(input logic [WordWidth-1:0] w);
    return w[AddrWidth-1:0];
  endfunction

  // A dereferenceable cons pointer: top bit clear, cons tag, non-zero address.
  function automatic logic is_cons_ptr(input logic [WordWidth-1:0] w);
    return (w[15] == 1'b0) && (word_type(w) == TYPE_CONS) && (word_addr(w) != '0);
  endfunction

endpackage

// File: rtl/cons_reader.sv
// Read-side heap initiator: dereferences a cons pointer into car/cdr, or walks
// a cdr chain (NTH), issuing one memory read at a time. A cell at address A
// keeps its car at A and its cdr at A-1.
module cons_reader
  import lisp_defs::*;
#(
  parameter int TimeoutCycles = 16,
  parameter int NthWidth      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [15:0]         ptr_in,
  input  logic [NthWidth-1:0] nth_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [15:0]         car_out,
  output logic [15:0]         cdr_out,
  output logic                mem_req,
  output logic [11:0]         mem_addr,
  input  logic                mem_data_ready,
  input  logic [15:0]         mem_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int                CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0]   CntLast = CntW'(TimeoutCycles - 1);

  state_t               state_q, state_d;
  reader_op_t           op_q, op_d;
  logic [15:0]          ptr_q, ptr_d;
  logic [NthWidth-1:0]  hop_q, hop_d;
  logic                 second_q, second_d;   // PAIR: car already fetched
  logic                 hopped_q, hopped_d;   // NTH: at least one cdr hop taken
  logic [CntW-1:0]      tmo_q, tmo_d;
  logic [15:0]          car_tmp_q, car_tmp_d; // PAIR car held until the cdr arrives
  logic                 err_q, err_d;
  reader_err_t          err_code_q, err_code_d;
  logic [15:0]          car_q, car_d;
  logic [15:0]          cdr_q, cdr_d;
  logic                 read_cdr;

  // Which half of the cell the current read targets.
  always_comb begin
    read_cdr = 1'b0;
    case (op_q)
      OP_CDR:  read_cdr = 1'b1;
      OP_PAIR: read_cdr = second_q;
      OP_NTH:  read_cdr = (hop_q != '0);
      default: read_cdr = 1'b0;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign mem_req  = (state_q == REQ);
  assign mem_addr = (state_q == REQ)
                    ? (read_cdr ? word_addr(ptr_q) - 12'd1 : word_addr(ptr_q))
                    : '0;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign car_out  = car_q;
  assign cdr_out  = cdr_q;

  // Next-state and datapath updates for the read sequencer.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ptr_d      = ptr_q;
    hop_d      = hop_q;
    second_d   = second_q;
    hopped_d   = hopped_q;
    tmo_d      = tmo_q;
    car_tmp_d  = car_tmp_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    car_d      = car_q;
    cdr_d      = cdr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = reader_op_t'(op);
          ptr_d    = ptr_in;
          hop_d    = nth_in;
          second_d = 1'b0;
          hopped_d = 1'b0;
          tmo_d    = '0;
          if (!is_cons_ptr(ptr_in)) begin
            // Rejected without touching memory.
            err_d      = 1'b1;
            err_code_d = ERR_TYPE;
            state_d    = DONE;
          end else begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            state_d    = REQ;
          end
        end
      end

      REQ: begin
        tmo_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (mem_data_ready) begin
          case (op_q)
            OP_CAR: begin
              car_d   = mem_data;
              state_d = DONE;
            end
            OP_CDR: begin
              cdr_d   = mem_data;
              state_d = DONE;
            end
            OP_PAIR: begin
              if (!second_q) begin
                car_tmp_d = mem_data;
                second_d  = 1'b1;
                state_d   = REQ;
              end else begin
                car_d   = car_tmp_q;
                cdr_d   = mem_data;
                state_d = DONE;
              end
            end
            default: begin  // OP_NTH
              if (hop_q != '0) begin
                if (mem_data == LISP_NIL) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_NIL;
                  state_d    = DONE;
                end else if (!is_cons_ptr(mem_data)) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_TYPE;
                  state_d    = DONE;
                end else begin
                  ptr_d    = mem_data;
                  hop_d    = hop_q - 1'b1;
                  hopped_d = 1'b1;
                  state_d  = REQ;
                end
              end else begin
                car_d = mem_data;
                // The pointer now holds the last cdr fetched on the walk.
                if (hopped_q) begin
                  cdr_d = ptr_q;
                end
                state_d = DONE;
              end
            end
          endcase
        end else if (tmo_q == CntLast) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin  // DONE
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_CAR;
      ptr_q      <= '0;
      hop_q      <= '0;
      second_q   <= 1'b0;
      hopped_q   <= 1'b0;
      tmo_q      <= '0;
      car_tmp_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      car_q      <= '0;
      cdr_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ptr_q      <= ptr_d;
      hop_q      <= hop_d;
      second_q   <= second_d;
      hopped_q   <= hopped_d;
      tmo_q      <= tmo_d;
      car_tmp_q  <= car_tmp_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      car_q      <= car_d;
      cdr_q      <= cdr_d;
    end
  end

endmodule

// File: tb/tb_cons_reader.sv
// Directed bench for cons_reader with a 1-cycle registered-read memory model.
module tb_cons_reader;
  import lisp_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] ptr_in;
  logic [7:0]  nth_in;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] car_out, cdr_out;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_data_ready;
  logic [15:0] mem_data;

  logic [15:0] mem [0:4095];
  logic        ready_q;
  logic        withhold;
  logic        ready_force;
  logic [11:0] addr_log [$];

  int checks = 0;
  int errors = 0;

  cons_reader #(.TimeoutCycles(16), .NthWidth(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ptr_in(ptr_in), .nth_in(nth_in),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .car_out(car_out), .cdr_out(cdr_out),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_ready(mem_data_ready), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory: answers a sampled request one cycle later unless withheld.
  always @(posedge clk) begin
    ready_q  <= mem_req && !withhold;
    mem_data <= mem[mem_addr];
  end
  assign mem_data_ready = ready_q | ready_force;

  // Log every request address as seen mid-cycle.
  always @(negedge clk) begin
    if (mem_req) addr_log.push_back(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one request and return the cycle (relative to the start edge) done is seen.
  task automatic run_op(input logic [1:0] o, input logic [15:0] p, input logic [7:0] n,
                        output int lat);
    @(negedge clk);
    addr_log.delete();
    op = o; ptr_in = p; nth_in = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] ptr;
    logic [7:0]  nth;
    int          lat;
    logic        err;
    logic [1:0]  code;
    logic [15:0] car;
    logic [15:0] cdr;
    int          reads;
    logic [11:0] a0;
    logic [11:0] a1;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lat;
    int cyc;
    bit saw_done;

    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h000] = 16'h0055;
    mem[12'h003] = 16'h0001; mem[12'h004] = 16'h0002;
    mem[12'h104] = 16'h0011; mem[12'h103] = 16'h1106;
    mem[12'h106] = 16'h0022; mem[12'h105] = 16'h1108;
    mem[12'h108] = 16'h0033; mem[12'h107] = 16'h0000;
    mem[12'h020] = 16'h0044; mem[12'h01F] = 16'h2005;
    mem[12'hFFF] = 16'h0066; mem[12'hFFE] = 16'h0077;

    //            op       ptr       n  lat err code      car       cdr      rd a0      a1
    vecs[0]  = '{OP_PAIR, 16'h1004, 0, 5, 1'b0, ERR_NONE,  16'h0002, 16'h0001, 2, 12'h004, 12'h003};
    vecs[1]  = '{OP_CAR,  16'h0001, 0, 1, 1'b1, ERR_TYPE,  16'h0002, 16'h0001, 0, 12'h000, 12'h000};
    vecs[2]  = '{OP_CDR,  16'h1104, 0, 3, 1'b0, ERR_NONE,  16'h0002, 16'h1106, 1, 12'h103, 12'h000};
    vecs[3]  = '{OP_CAR,  16'h1106, 0, 3, 1'b0, ERR_NONE,  16'h0022, 16'h1106, 1, 12'h106, 12'h000};
    vecs[4]  = '{OP_NTH,  16'h1104, 2, 7, 1'b0, ERR_NONE,  16'h0033, 16'h1108, 3, 12'h103, 12'h105};
    vecs[5]  = '{OP_NTH,  16'h1104, 3, 7, 1'b1, ERR_NIL,   16'h0033, 16'h1108, 3, 12'h103, 12'h105};
    vecs[6]  = '{OP_NTH,  16'h1104, 0, 3, 1'b0, ERR_NONE,  16'h0011, 16'h1108, 1, 12'h104, 12'h000};
    vecs[7]  = '{OP_NTH,  16'h1020, 1, 3, 1'b1, ERR_TYPE,  16'h0011, 16'h1108, 1, 12'h01F, 12'h000};
    vecs[8]  = '{OP_CAR,  16'h1000, 0, 1, 1'b1, ERR_TYPE,  16'h0011, 16'h1108, 0, 12'h000, 12'h000};
    vecs[9]  = '{OP_CAR,  16'h0000, 0, 1, 1'b1, ERR_TYPE,  16'h0011, 16'h1108, 0, 12'h000, 12'h000};
    vecs[10] = '{OP_CDR,  16'h1001, 0, 3, 1'b0, ERR_NONE,  16'h0011, 16'h0055, 1, 12'h000, 12'h000};
    vecs[11] = '{OP_PAIR, 16'h1FFF, 0, 5, 1'b0, ERR_NONE,  16'h0066, 16'h0077, 2, 12'hFFF, 12'hFFE};

    rst = 1'b1; start = 1'b0; op = 2'd0; ptr_in = '0; nth_in = '0;
    withhold = 1'b0; ready_force = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_code", err_code, 0);
    check("reset_car", car_out, 0);
    check("reset_cdr", cdr_out, 0);
    check("reset_req", mem_req, 0);
    check("reset_addr", mem_addr, 0);

    // Table-driven single requests
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].ptr, vecs[i].nth, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_err", i), err, vecs[i].err);
      check($sformatf("v%0d_code", i), err_code, vecs[i].code);
      check($sformatf("v%0d_car", i), car_out, vecs[i].car);
      check($sformatf("v%0d_cdr", i), cdr_out, vecs[i].cdr);
      check($sformatf("v%0d_reads", i), addr_log.size(), vecs[i].reads);
      if (vecs[i].reads > 0 && addr_log.size() > 0)
        check($sformatf("v%0d_addr0", i), addr_log[0], vecs[i].a0);
      if (vecs[i].reads > 1 && addr_log.size() > 1)
        check($sformatf("v%0d_addr1", i), addr_log[1], vecs[i].a1);
      $display("vec %0d op=%0d ptr=%h n=%0d lat=%0d err=%0d code=%0d car=%h cdr=%h",
               i, vecs[i].op, vecs[i].ptr, vecs[i].nth, lat, err, err_code, car_out, cdr_out);
    end

    // Timeout: memory never answers
    withhold = 1'b1;
    run_op(OP_CAR, 16'h1004, 8'd0, lat);
    withhold = 1'b0;
    check("tmo_latency", lat, 18);
    check("tmo_err", err, 1);
    check("tmo_code", err_code, ERR_TIMEOUT);
    check("tmo_car", car_out, 16'h0066);
    check("tmo_cdr", cdr_out, 16'h0077);
    $display("timeout lat=%0d err=%0d code=%0d", lat, err, err_code);

    // start held high through busy and the DONE cycle is ignored
    @(negedge clk);
    addr_log.delete();
    op = OP_PAIR; ptr_in = 16'h1004; nth_in = 8'd0; start = 1'b1;
    @(negedge clk);
    op = OP_CAR; ptr_in = 16'h1106;
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_start_latency", cyc, 5);
    check("busy_start_car", car_out, 16'h0002);
    check("busy_start_cdr", cdr_out, 16'h0001);
    check("busy_start_reads", addr_log.size(), 2);
    @(negedge clk);
    check("after_done_idle", busy, 0);
    start = 1'b0;
    $display("busy-start lat=%0d car=%h cdr=%h", cyc, car_out, cdr_out);

    // Reset while waiting, then a stray ready must not complete anything
    @(negedge clk);
    withhold = 1'b1;
    op = OP_CAR; ptr_in = 16'h1004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("wait_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    ready_force = 1'b1;
    @(negedge clk);
    ready_force = 1'b0;
    withhold = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    check("late_ready_no_done", saw_done, 0);
    check("rst_car_cleared", car_out, 0);
    $display("reset-in-wait busy=%0d done_seen=%0d", busy, saw_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
